// File: rtl/color_history_updater.sv
// Read-modify-write front end for the color_history buffer: issues reads, scores returned
// history, writes back saturating persistence, counts hits per frame. Optional macro: HIST_FWD_EN.
module color_history_updater #(
  parameter int READ_LAT = 3,
  parameter int INC      = 2,
  parameter int DEC      = 1,
  parameter int THRESH   = 8,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_hit,
  output logic        pix_ready,
  output logic [9:0]  hist_read_x,
  output logic [9:0]  hist_read_y,
  input  logic [3:0]  hist_read_data,
  input  logic        hist_data_valid,
  input  logic [9:0]  hist_just_read_x,
  input  logic [9:0]  hist_just_read_y,
  output logic [9:0]  hist_write_x,
  output logic [9:0]  hist_write_y,
  output logic [3:0]  hist_write_data,
  output logic        hist_write_en,
  output logic [18:0] hit_count,
  output logic        frame_done,
  output logic        sync_err
);

  typedef enum logic [1:0] {WAIT_CLR, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [9:0]         rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic               wen_q, wen_d;
  logic [9:0]         wx_q, wx_d, wy_q, wy_d;
  logic [3:0]         wd_q, wd_d;
  logic [18:0]        cnt_q, cnt_d, hc_q, hc_d;
  logic               fdn_q, fdn_d;
  logic               se_q, se_d;

  // Tag pipe: stage 0 sits beside the read address register, stage READ_LAT meets the response.
  logic [READ_LAT:0]  tv_q;
  logic [9:0]         tx_q [0:READ_LAT];
  logic [9:0]         ty_q [0:READ_LAT];
  logic               th_q [0:READ_LAT];

  logic               accept, ex_v, match, last_px;
  logic [3:0]         old_score, new_score;
  logic [18:0]        cnt_inc;

  function automatic logic [3:0] sat_score(input logic [3:0] old, input logic hit);
    logic [4:0] s;
    if (hit) begin
      s = {1'b0, old} + 5'(INC);
      if (s > 5'd15) s = 5'd15;
    end else if ({1'b0, old} < 5'(DEC)) begin
      s = 5'd0;
    end else begin
      s = {1'b0, old} - 5'(DEC);
    end
    return s[3:0];
  endfunction

  assign pix_ready = (state_q == RUN) & hist_data_valid;
  assign accept    = pix_valid & pix_ready;
  assign ex_v      = tv_q[READ_LAT];
  assign match     = ex_v & hist_data_valid &
                     (hist_just_read_x == tx_q[READ_LAT]) & (hist_just_read_y == ty_q[READ_LAT]);
  assign last_px   = (tx_q[READ_LAT] == 10'(WIDTH - 1)) & (ty_q[READ_LAT] == 10'(HEIGHT - 1));

`ifdef HIST_FWD_EN
  logic               fv_q [0:READ_LAT-1];
  logic [9:0]         fx_q [0:READ_LAT-1];
  logic [9:0]         fy_q [0:READ_LAT-1];
  logic [3:0]         fd_q [0:READ_LAT-1];

  // Oldest history entry first so the newest matching write wins.
  always_comb begin
    old_score = hist_read_data;
    for (int k = READ_LAT - 1; k >= 0; k--) begin
      if (fv_q[k] && fx_q[k] == tx_q[READ_LAT] && fy_q[k] == ty_q[READ_LAT]) old_score = fd_q[k];
    end
    if (wen_q && wx_q == tx_q[READ_LAT] && wy_q == ty_q[READ_LAT]) old_score = wd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < READ_LAT; k++) fv_q[k] <= 1'b0;
    end else begin
      fv_q[0] <= wen_q;
      for (int k = 1; k < READ_LAT; k++) fv_q[k] <= fv_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    fx_q[0] <= wx_q;
    fy_q[0] <= wy_q;
    fd_q[0] <= wd_q;
    for (int k = 1; k < READ_LAT; k++) begin
      fx_q[k] <= fx_q[k-1];
      fy_q[k] <= fy_q[k-1];
      fd_q[k] <= fd_q[k-1];
    end
  end
`else
  assign old_score = hist_read_data;
`endif

  assign new_score = sat_score(old_score, th_q[READ_LAT]);
  assign cnt_inc   = cnt_q + 19'({1'b0, new_score} >= 5'(THRESH));

  always_comb begin
    state_d = state_q;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    wen_d   = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    hc_d    = hc_q;
    fdn_d   = 1'b0;
    se_d    = se_q;
    case (state_q)
      WAIT_CLR: if (hist_data_valid) state_d = RUN;
      RUN:      if (accept && pix_x == 10'(WIDTH - 1) && pix_y == 10'(HEIGHT - 1)) state_d = DRAIN;
      DRAIN:    if (tv_q == '0) state_d = RUN;
      default:  state_d = WAIT_CLR;
    endcase
    if (accept) begin
      rd_x_d = pix_x;
      rd_y_d = pix_y;
    end
    if (ex_v) begin
      if (match) begin
        wen_d = 1'b1;
        wx_d  = tx_q[READ_LAT];
        wy_d  = ty_q[READ_LAT];
        wd_d  = new_score;
        if (last_px) begin
          hc_d  = cnt_inc;
          fdn_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        se_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_CLR;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      wen_q   <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      hc_q    <= '0;
      fdn_q   <= 1'b0;
      se_q    <= 1'b0;
      tv_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      wen_q   <= wen_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      hc_q    <= hc_d;
      fdn_q   <= fdn_d;
      se_q    <= se_d;
      tv_q    <= {tv_q[READ_LAT-1:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    tx_q[0] <= pix_x;
    ty_q[0] <= pix_y;
    th_q[0] <= pix_hit;
    for (int k = 1; k <= READ_LAT; k++) begin
      tx_q[k] <= tx_q[k-1];
      ty_q[k] <= ty_q[k-1];
      th_q[k] <= th_q[k-1];
    end
  end

  assign hist_read_x     = rd_x_q;
  assign hist_read_y     = rd_y_q;
  assign hist_write_x    = wx_q;
  assign hist_write_y    = wy_q;
  assign hist_write_data = wd_q;
  assign hist_write_en   = wen_q;
  assign hit_count       = hc_q;
  assign frame_done      = fdn_q;
  assign sync_err        = se_q;

endmodule
